pc_trace_monitor: RTL and testbench
===================================

# pc_trace_monitor

Synthesizable observer sitting on the consuming end of the single-cycle CPU's `pc_out` stream. It counts cycles and fetches, keeps a circular history of the most recent distinct PCs, flags misaligned PCs, and detects a halt (PC stuck on one value). Benches and the FPGA debug path read its outputs in place of per-cycle `$display` tracing.

## Interface
- `HIST_DEPTH`, 8: history entries; power of two, ≥2.
- `HALT_CYCLES`, 4: consecutive samples of an unchanged PC that declare a halt; ≥2.
- `CNT_W`, 16: width of both counters.
- `HIST_AW`, derived localparam = clog2(`HIST_DEPTH`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  PC from CPU `pc_out`, sampled every rising edge.
- `hist_idx`  in  `HIST_AW`  history read index; 0 = most recent entry.
- `hist_pc`  out  32  history entry at `hist_idx`; 0 when `hist_idx` ≥ `hist_cnt`.
- `hist_cnt`  out  `HIST_AW`+1  valid history entries; saturates at `HIST_DEPTH`.
- `cycle_cnt`  out  `CNT_W`  rising edges spent in RUN or HALT; saturating.
- `fetch_cnt`  out  `CNT_W`  pushes into history (distinct-PC fetches); saturating.
- `halted`  out  1  high while in HALT.
- `misaligned`  out  1  sticky; set on any sampled `pc_in[1:0]` ≠ 0.
- `state`  out  2  IDLE=0, RUN=1, HALT=2.

## Operation
- Reset, synchronous, `rst`=1 at an edge: state IDLE. All outputs 0. `last_pc`, write pointer, stall counter and history RAM cleared to 0.
- IDLE: on the first edge with `rst`=0:
  - sample `pc_in` as the first fetch: push it, `last_pc` ← `pc_in`, `fetch_cnt`=1, `cycle_cnt`=1;
  - go to RUN.
- RUN, each edge:
  - `cycle_cnt`++.
  - If `pc_in` ≠ `last_pc`: push `pc_in`, `fetch_cnt`++, `last_pc` ← `pc_in`, stall counter ← 0.
  - Otherwise: stall counter++. When it reaches `HALT_CYCLES`-1 (i.e. `HALT_CYCLES` equal consecutive samples including the first), go to HALT.
- HALT:
  - `cycle_cnt`++.
  - If `pc_in` ≠ `last_pc`: push, `fetch_cnt`++, stall counter ← 0, return to RUN.
  - Otherwise stay.
- Push: RAM[wr_ptr] ← `pc_in`; wr_ptr ← wr_ptr+1, wrapping modulo `HIST_DEPTH`; `hist_cnt`++ until `HIST_DEPTH`. The oldest entry is overwritten on wrap.
- Read: `hist_pc` = RAM[(wr_ptr − 1 − `hist_idx`) mod `HIST_DEPTH`] when `hist_idx` < `hist_cnt`, else 0.
- `misaligned`: evaluated on every sample in IDLE→RUN, RUN and HALT. Once set, cleared only by reset.
- Counters saturate at all-ones and never wrap.
- `rst` asserted mid-operation (any state): next edge applies full reset, regardless of other inputs.

## Timing
- `cycle_cnt`, `fetch_cnt`, `hist_cnt`, `halted`, `misaligned` and `state` are registered and reflect the sample taken at the previous edge.
- `hist_pc` is combinational from `hist_idx` and registered RAM/pointer state, so the read has zero latency. A push at edge N is visible at index 0 right after edge N.
- Halt latency: if the PC first repeats at edge K, `halted` rises after edge K+`HALT_CYCLES`−2, counting from the first equal sample. With default 4 and PC stuck starting at edge T, `halted` is high after edge T+3.
- Push and halt exit on the same edge: the new PC is recorded and `halted` falls after that edge.

## Structure
- Shared package `cpu_dbg_pkg`:
  - state encodings IDLE/RUN/HALT;
  - PC width constant 32;
  - default `HIST_DEPTH`/`HALT_CYCLES`.
- One sub-module, `pc_hist_buf`: circular buffer with push, wr_ptr, count, and the indexed newest-first combinational read.
- The top holds the FSM, stall counter, saturating counters and the alignment flag.

## Test plan
- Reset, then PC 0,4,8,C,10 on consecutive edges:
  - `fetch_cnt`=5, `cycle_cnt`=5, `state`=RUN;
  - `hist_pc`[0]=10, [4]=0;
  - `hist_cnt`=5; `hist_idx`=5 reads 0.
- Wrap: push 12 distinct PCs 0x0..0x2C step 4 with `HIST_DEPTH`=8:
  - `hist_cnt`=8;
  - `hist_pc`[0]=2C, [7]=10.
- Halt: PC 0,4,8 then 8 held:
  - `halted`=1 after the 4th consecutive sample of 8;
  - then PC=C: `halted`=0, `state`=RUN, `hist_pc`[0]=C, `fetch_cnt`=4.
- Misaligned: PC 0,4,6,8: `misaligned`=1 after sampling 6 and remains 1 through 8 and HALT.
- Mid-run reset: assert `rst` for one edge while in HALT: all outputs 0, `state`=IDLE; the next PC 0 gives `fetch_cnt`=1.
- Saturation with `CNT_W`=4: 20 distinct PCs give `cycle_cnt`=`fetch_cnt`=F.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared definitions for the CPU debug observers.
//   PC_W             : width of a program counter value
//   DEF_HIST_DEPTH   : default number of PC history entries
//   DEF_HALT_CYCLES  : default count of equal PC samples that mean "halted"
//   dbg_state_e      : trace monitor state encoding (IDLE=0, RUN=1, HALT=2)
package cpu_dbg_pkg;

    localparam int PC_W            = 32;
    localparam int DEF_HIST_DEPTH  = 8;
    localparam int DEF_HALT_CYCLES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } dbg_state_e;

endpackage

// File: rtl/pc_hist_buf.sv
// Circular history of pushed PC values with a newest-first indexed read.
//   clk, rst : clock and synchronous active-high reset (clears RAM too)
//   push     : write push_pc at the write pointer and advance it
//   push_pc  : PC value to record
//   rd_idx   : read index, 0 = most recent entry
//   rd_pc    : entry at rd_idx, or 0 when rd_idx is not a valid entry
//   count    : number of valid entries, saturating at DEPTH
module pc_hist_buf
    import cpu_dbg_pkg::*;
#(
    parameter  int DEPTH = DEF_HIST_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [PC_W-1:0] push_pc,
    input  logic [AW-1:0]   rd_idx,
    output logic [PC_W-1:0] rd_pc,
    output logic [AW:0]     count
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [PC_W-1:0] ram [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     cnt_q;
    logic [AW-1:0]   rd_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ram[i] <= '0;
            end
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (push) begin
            ram[wr_ptr] <= push_pc;
            wr_ptr      <= wr_ptr + AW'(1);
            if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end
        end
    end

    // DEPTH is a power of two, so AW-bit arithmetic wraps modulo DEPTH for free.
    assign rd_addr = wr_ptr - AW'(1) - rd_idx;
    assign rd_pc   = ({1'b0, rd_idx} < cnt_q) ? ram[rd_addr] : '0;
    assign count   = cnt_q;

endmodule

// File: rtl/pc_trace_monitor.sv
// Observer on the CPU pc_out stream: counts cycles and distinct-PC fetches,
// records recent distinct PCs, flags misaligned PCs and detects a stuck PC.
//   clk, rst   : clock and synchronous active-high reset
//   pc_in      : PC sampled every rising edge
//   hist_idx   : history read index (0 = newest)
//   hist_pc    : history entry at hist_idx (combinational), 0 if invalid
//   hist_cnt   : valid history entries, saturating at HIST_DEPTH
//   cycle_cnt  : edges spent in RUN or HALT, saturating
//   fetch_cnt  : history pushes, saturating
//   halted     : high while in HALT
//   misaligned : sticky flag for any sampled PC with nonzero low bits
//   state      : IDLE=0, RUN=1, HALT=2
module pc_trace_monitor
    import cpu_dbg_pkg::*;
#(
    parameter  int HIST_DEPTH  = DEF_HIST_DEPTH,
    parameter  int HALT_CYCLES = DEF_HALT_CYCLES,
    parameter  int CNT_W       = 16,
    localparam int HIST_AW     = $clog2(HIST_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [HIST_AW-1:0] hist_idx,
    output logic [PC_W-1:0]    hist_pc,
    output logic [HIST_AW:0]   hist_cnt,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   fetch_cnt,
    output logic               halted,
    output logic               misaligned,
    output logic [1:0]         state
);

    // Stall counter holds up to HALT_CYCLES-1. The HALT transition fires on the
    // edge where the counter would step from HALT_CYCLES-2 to HALT_CYCLES-1.
    localparam int                STALL_W   = $clog2(HALT_CYCLES);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(HALT_CYCLES - 2);

    dbg_state_e          state_q, state_d;
    logic [PC_W-1:0]     last_pc_q;
    logic [STALL_W-1:0]  stall_q;
    logic [CNT_W-1:0]    cycle_q, fetch_q;
    logic                misaligned_q;
    logic                push;
    logic                pc_changed;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign pc_changed = (pc_in != last_pc_q);

    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                push    = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (pc_changed) begin
                    push = 1'b1;
                end else if (stall_q == STALL_PRE) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (pc_changed) begin
                    push    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_pc_q    <= '0;
            stall_q      <= '0;
            cycle_q      <= '0;
            fetch_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // IDLE always leaves for RUN, so every non-reset edge is a counted edge.
            cycle_q <= sat_inc(cycle_q);
            if (pc_in[1:0] != 2'b00) begin
                misaligned_q <= 1'b1;
            end
            if (push) begin
                last_pc_q <= pc_in;
                fetch_q   <= sat_inc(fetch_q);
                stall_q   <= '0;
            end else if (state_q == ST_RUN) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

    pc_hist_buf #(
        .DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_pc (pc_in),
        .rd_idx  (hist_idx),
        .rd_pc   (hist_pc),
        .count   (hist_cnt)
    );

    assign cycle_cnt  = cycle_q;
    assign fetch_cnt  = fetch_q;
    assign halted     = (state_q == ST_HALT);
    assign misaligned = misaligned_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pc_trace_monitor.sv
module tb_pc_trace_monitor;

    localparam int K_CYC   = 0;
    localparam int K_FET   = 1;
    localparam int K_HCNT  = 2;
    localparam int K_HALT  = 3;
    localparam int K_MIS   = 4;
    localparam int K_ST    = 5;
    localparam int K_HPC   = 6;
    localparam int K_CYC4  = 7;
    localparam int K_FET4  = 8;

    typedef struct {
        int          cyc;
        int          kind;
        int          idx;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [2:0]  hist_idx;

    logic [31:0] hist_pc;
    logic [3:0]  hist_cnt;
    logic [15:0] cycle_cnt, fetch_cnt;
    logic        halted, misaligned;
    logic [1:0]  state;

    logic [31:0] hist_pc_4;
    logic [3:0]  hist_cnt_4;
    logic [3:0]  cycle_cnt_4, fetch_cnt_4;
    logic        halted_4, misaligned_4;
    logic [1:0]  state_4;

    chk_t sb[$];
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pc_trace_monitor u_dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .hist_idx   (hist_idx),
        .hist_pc    (hist_pc),
        .hist_cnt   (hist_cnt),
        .cycle_cnt  (cycle_cnt),
        .fetch_cnt  (fetch_cnt),
        .halted     (halted),
        .misaligned (misaligned),
        .state      (state)
    );

    pc_trace_monitor #(.CNT_W(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .hist_idx   (hist_idx),
        .hist_pc    (hist_pc_4),
        .hist_cnt   (hist_cnt_4),
        .cycle_cnt  (cycle_cnt_4),
        .fetch_cnt  (fetch_cnt_4),
        .halted     (halted_4),
        .misaligned (misaligned_4),
        .state      (state_4)
    );

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_CYC:   return {16'd0, cycle_cnt};
            K_FET:   return {16'd0, fetch_cnt};
            K_HCNT:  return {28'd0, hist_cnt};
            K_HALT:  return {31'd0, halted};
            K_MIS:   return {31'd0, misaligned};
            K_ST:    return {30'd0, state};
            K_HPC:   return hist_pc;
            K_CYC4:  return {28'd0, cycle_cnt_4};
            K_FET4:  return {28'd0, fetch_cnt_4};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: after each rising edge, compare every expectation tagged for it.
    initial begin
        chk_t        c;
        logic [31:0] act;
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= edge_n) begin
                c = sb.pop_front();
                if (c.kind == K_HPC) begin
                    hist_idx = c.idx[2:0];
                    #1;
                end
                act = actual(c.kind);
                checks++;
                if (c.cyc != edge_n || act !== c.exp) begin
                    errors++;
                    $display("FAIL %s at edge %0d: got %h expected %h", c.name, edge_n, act, c.exp);
                end
            end
        end
    end

    // Drive one sample: inputs change on the falling edge, sampled on the next rising edge.
    task automatic step(input logic [31:0] pc, input logic r);
        @(negedge clk);
        pc_in = pc;
        rst   = r;
    endtask

    // Expectation for the outputs right after the edge that samples the last step.
    task automatic expect_v(input int kind, input int idx, input logic [31:0] v, input string name);
        chk_t c;
        c.cyc  = edge_n + 1;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = v;
        c.name = name;
        sb.push_back(c);
    endtask

    task automatic do_reset(input string tag);
        step(32'h0, 1'b1);
        expect_v(K_CYC,  0, 32'd0, {tag, "_rst_cycle"});
        expect_v(K_FET,  0, 32'd0, {tag, "_rst_fetch"});
        expect_v(K_HCNT, 0, 32'd0, {tag, "_rst_hcnt"});
        expect_v(K_ST,   0, 32'd0, {tag, "_rst_state"});
        expect_v(K_HALT, 0, 32'd0, {tag, "_rst_halted"});
        expect_v(K_MIS,  0, 32'd0, {tag, "_rst_mis"});
        expect_v(K_HPC,  0, 32'd0, {tag, "_rst_hpc0"});
    endtask

    initial begin
        rst      = 1'b1;
        pc_in    = 32'h0;
        hist_idx = 3'd0;

        // Basic sequence 0,4,8,C,10
        do_reset("seq");
        step(32'h0, 1'b0);
        expect_v(K_FET, 0, 32'd1, "seq_first_fetch");
        expect_v(K_CYC, 0, 32'd1, "seq_first_cycle");
        expect_v(K_ST,  0, 32'd1, "seq_first_state");
        step(32'h4, 1'b0);
        step(32'h8, 1'b0);
        step(32'hC, 1'b0);
        step(32'h10, 1'b0);
        expect_v(K_FET,  0, 32'd5,  "seq_fetch");
        expect_v(K_CYC,  0, 32'd5,  "seq_cycle");
        expect_v(K_ST,   0, 32'd1,  "seq_state");
        expect_v(K_HCNT, 0, 32'd5,  "seq_hcnt");
        expect_v(K_HPC,  0, 32'h10, "seq_hpc0");
        expect_v(K_HPC,  4, 32'h0,  "seq_hpc4");
        expect_v(K_HPC,  5, 32'h0,  "seq_hpc5_invalid");

        // Wrap: 12 distinct PCs into 8 entries
        do_reset("wrap");
        for (int i = 0; i < 12; i++) step(32'(i * 4), 1'b0);
        expect_v(K_HCNT, 0, 32'd8,  "wrap_hcnt");
        expect_v(K_FET,  0, 32'd12, "wrap_fetch");
        expect_v(K_CYC,  0, 32'd12, "wrap_cycle");
        expect_v(K_HPC,  0, 32'h2C, "wrap_hpc0");
        expect_v(K_HPC,  7, 32'h10, "wrap_hpc7");
        expect_v(K_HPC,  3, 32'h20, "wrap_hpc3");

        // Halt: 0,4,8 then 8 held
        do_reset("halt");
        step(32'h0, 1'b0);
        step(32'h4, 1'b0);
        step(32'h8, 1'b0);
        step(32'h8, 1'b0);
        step(32'h8, 1'b0);
        expect_v(K_HALT, 0, 32'd0, "halt_not_yet");
        expect_v(K_ST,   0, 32'd1, "halt_not_yet_state");
        step(32'h8, 1'b0);
        expect_v(K_HALT, 0, 32'd1, "halt_set");
        expect_v(K_ST,   0, 32'd2, "halt_state");
        step(32'h8, 1'b0);
        expect_v(K_HALT, 0, 32'd1, "halt_held");
        expect_v(K_CYC,  0, 32'd7, "halt_cycle");
        expect_v(K_FET,  0, 32'd3, "halt_fetch");
        step(32'hC, 1'b0);
        expect_v(K_HALT, 0, 32'd0, "halt_exit");
        expect_v(K_ST,   0, 32'd1, "halt_exit_state");
        expect_v(K_HPC,  0, 32'hC, "halt_exit_hpc0");
        expect_v(K_FET,  0, 32'd4, "halt_exit_fetch");
        expect_v(K_CYC,  0, 32'd8, "halt_exit_cycle");

        // Misaligned PC, then mid-run reset from HALT
        do_reset("mis");
        step(32'h0, 1'b0);
        step(32'h4, 1'b0);
        expect_v(K_MIS, 0, 32'd0, "mis_clean");
        step(32'h6, 1'b0);
        expect_v(K_MIS, 0, 32'd1, "mis_set");
        step(32'h8, 1'b0);
        expect_v(K_MIS, 0, 32'd1, "mis_sticky");
        step(32'h8, 1'b0);
        step(32'h8, 1'b0);
        step(32'h8, 1'b0);
        expect_v(K_ST,  0, 32'd2, "mis_halt_state");
        expect_v(K_MIS, 0, 32'd1, "mis_in_halt");
        do_reset("midrst");
        step(32'h0, 1'b0);
        expect_v(K_FET, 0, 32'd1, "midrst_fetch");
        expect_v(K_CYC, 0, 32'd1, "midrst_cycle");
        expect_v(K_ST,  0, 32'd1, "midrst_state");

        // Saturation on the 4-bit counter instance
        do_reset("sat");
        for (int i = 0; i < 15; i++) step(32'(i * 4), 1'b0);
        expect_v(K_CYC4, 0, 32'hF, "sat_cycle_at_15");
        for (int i = 15; i < 20; i++) step(32'(i * 4), 1'b0);
        expect_v(K_CYC4, 0, 32'hF,   "sat_cycle4");
        expect_v(K_FET4, 0, 32'hF,   "sat_fetch4");
        expect_v(K_CYC,  0, 32'd20,  "sat_cycle16");
        expect_v(K_FET,  0, 32'd20,  "sat_fetch16");
        expect_v(K_HPC,  0, 32'h4C,  "sat_hpc0");

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
